// File: rtl/menu_sequencer.sv
// ATM menu page sequencer: button presses move the shown page, gate the per-page
// scrollers, time idle browsing back to page 0 and offer the chosen page over valid/ack.
module menu_sequencer #(
  parameter int         NUM_PAGES      = 4,
  parameter logic [3:0] MENU_STATE     = 4'd0,
  parameter int         TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_sel,
  input  logic [3:0]           state,
  input  logic                 sel_ack,
  output logic [1:0]           page,
  output logic [NUM_PAGES-1:0] scroll_rst,
  output logic                 sel_valid,
  output logic [1:0]           sel_op,
  output logic                 timeout
);

  // state    | meaning
  // S_IDLE   | menu not live, page 0, all scrollers held
  // S_BROWSE | page moves on up/down presses, idle timer running off page 0
  // S_CONFIRM| selection offered to main FSM, waiting for sel_ack
  typedef enum logic [1:0] {S_IDLE, S_BROWSE, S_CONFIRM} fsm_t;

  localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [1:0]       LAST_PAGE = 2'(NUM_PAGES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  fsm_t                 fsm_q, fsm_d;
  logic [1:0]           page_q, page_d;
  logic [NUM_PAGES-1:0] scroll_rst_q, scroll_rst_d;
  logic                 sel_valid_q, sel_valid_d;
  logic [1:0]           sel_op_q, sel_op_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           btn_q, btn_d;
  logic                 restart;
  logic                 press_up, press_down, press_sel;

  assign btn_d      = {btn_sel, btn_down, btn_up};
  assign press_up   = btn_up   & ~btn_q[0];
  assign press_down = btn_down & ~btn_q[1];
  assign press_sel  = btn_sel  & ~btn_q[2];

  always_comb begin
    fsm_d       = fsm_q;
    page_d      = page_q;
    sel_valid_d = sel_valid_q;
    sel_op_d    = sel_op_q;
    timeout_d   = 1'b0;
    cnt_d       = cnt_q;
    restart     = 1'b0;

    if (state != MENU_STATE) begin
      fsm_d       = S_IDLE;
      page_d      = 2'd0;
      sel_valid_d = 1'b0;
      cnt_d       = '0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          fsm_d   = S_BROWSE;
          page_d  = 2'd0;
          cnt_d   = '0;
          restart = 1'b1;
        end
        S_BROWSE: begin
          if (press_sel) begin
            fsm_d       = S_CONFIRM;
            sel_valid_d = 1'b1;
            sel_op_d    = page_q;
            cnt_d       = '0;
          end else if (press_up ^ press_down) begin
            if (press_up) page_d = (page_q == 2'd0) ? LAST_PAGE : page_q - 2'd1;
            else          page_d = (page_q == LAST_PAGE) ? 2'd0 : page_q + 2'd1;
            restart = 1'b1;
            cnt_d   = '0;
          end else if (press_up && press_down) begin
            cnt_d = '0;
          end else if (page_q == 2'd0) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            page_d    = 2'd0;
            timeout_d = 1'b1;
            restart   = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_CONFIRM: begin
          cnt_d = '0;
          if (sel_ack && sel_valid_q) begin
            sel_valid_d = 1'b0;
            fsm_d       = S_BROWSE;
          end
        end
        default: fsm_d = S_IDLE;
      endcase
    end

    // The shown scroller is held for one cycle after any page change so it starts at frame 0.
    for (int i = 0; i < NUM_PAGES; i++) begin
      scroll_rst_d[i] = (fsm_d == S_IDLE) || restart || (page_d != 2'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q        <= S_IDLE;
      page_q       <= 2'd0;
      scroll_rst_q <= '1;
      sel_valid_q  <= 1'b0;
      sel_op_q     <= 2'd0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
      btn_q        <= 3'b111;
    end else begin
      fsm_q        <= fsm_d;
      page_q       <= page_d;
      scroll_rst_q <= scroll_rst_d;
      sel_valid_q  <= sel_valid_d;
      sel_op_q     <= sel_op_d;
      timeout_q    <= timeout_d;
      cnt_q        <= cnt_d;
      btn_q        <= btn_d;
    end
  end

  assign page       = page_q;
  assign scroll_rst = scroll_rst_q;
  assign sel_valid  = sel_valid_q;
  assign sel_op     = sel_op_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_menu_sequencer.sv
// Bench for menu_sequencer: directed scenarios plus random stimulus against a
// cycle-level behavioural model of the menu rules.
module tb_menu_sequencer;
  localparam int NP = 4;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst, btn_up, btn_down, btn_sel, sel_ack;
  logic [3:0] state;
  logic [1:0] page, sel_op;
  logic [NP-1:0] scroll_rst;
  logic       sel_valid, timeout;

  int vectors = 0;
  int errors  = 0;

  menu_sequencer #(.NUM_PAGES(NP), .MENU_STATE(4'd0), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
    .state(state), .sel_ack(sel_ack), .page(page), .scroll_rst(scroll_rst),
    .sel_valid(sel_valid), .sel_op(sel_op), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: menu live / confirming flags, page number, idle cycle count.
  bit m_live, m_conf, m_selv, m_to, m_fresh;
  int m_page, m_op, m_idle;
  bit pv_up, pv_dn, pv_sel;

  function automatic logic [NP-1:0] m_scroll();
    if (!m_live || m_fresh) return '1;
    return ~(NP'(1) << m_page);
  endfunction

  task automatic tick();
    bit pu, pd, ps;
    @(posedge clk);
    pu = btn_up && !pv_up;
    pd = btn_down && !pv_dn;
    ps = btn_sel && !pv_sel;
    m_to = 0;
    m_fresh = 0;
    if (!rst) begin
      m_live = 0; m_conf = 0; m_selv = 0; m_page = 0; m_op = 0; m_idle = 0;
      pv_up = 1; pv_dn = 1; pv_sel = 1;
    end else begin
      if (state != 4'd0) begin
        m_live = 0; m_conf = 0; m_selv = 0; m_page = 0; m_idle = 0;
      end else if (!m_live) begin
        m_live = 1; m_page = 0; m_fresh = 1; m_idle = 0;
      end else if (m_conf) begin
        m_idle = 0;
        if (sel_ack) begin m_conf = 0; m_selv = 0; end
      end else if (ps) begin
        m_conf = 1; m_selv = 1; m_op = m_page; m_idle = 0;
      end else if (pu != pd) begin
        m_page = (m_page + (pu ? NP - 1 : 1)) % NP;
        m_fresh = 1; m_idle = 0;
      end else if (pu && pd) begin
        m_idle = 0;
      end else if (m_page == 0) begin
        m_idle = 0;
      end else if (m_idle == TO - 1) begin
        m_page = 0; m_to = 1; m_fresh = 1; m_idle = 0;
      end else begin
        m_idle++;
      end
      pv_up = btn_up; pv_dn = btn_down; pv_sel = btn_sel;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 0; btn_up = 1; btn_down = 0; btn_sel = 0; sel_ack = 0; state = 4'd0;
    tick(); tick();
    vectors++; if (page !== 2'd0) begin errors++; $display("FAIL rst_page: got %0d want 0", page); end
    vectors++; if (scroll_rst !== 4'b1111) begin errors++; $display("FAIL rst_scroll: got %b want 1111", scroll_rst); end
    vectors++; if (sel_valid !== 1'b0 || sel_op !== 2'd0 || timeout !== 1'b0) begin
      errors++; $display("FAIL rst_sel: got valid=%b op=%0d to=%b want 0 0 0", sel_valid, sel_op, timeout); end
    rst = 1;
    tick();
    vectors++; if (scroll_rst !== 4'b1111 || page !== 2'd0) begin
      errors++; $display("FAIL entry_restart: got page=%0d scroll=%b want 0 1111", page, scroll_rst); end
    tick();
    vectors++; if (scroll_rst !== 4'b1110) begin errors++; $display("FAIL entry_run: got %b want 1110", scroll_rst); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (page !== 2'd0) begin errors++; $display("FAIL held_up_%0d: got page %0d want 0", i, page); end
    end
  endtask

  task automatic test_up_wrap();
    logic [1:0] exp_p[4] = '{2'd3, 2'd2, 2'd1, 2'd0};
    logic [3:0] exp_s[4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    btn_up = 0; tick();
    for (int k = 0; k < 4; k++) begin
      btn_up = 1; tick();
      vectors++; if (page !== exp_p[k] || scroll_rst !== 4'b1111) begin
        errors++; $display("FAIL up_%0d: got page=%0d scroll=%b want %0d 1111", k, page, scroll_rst, exp_p[k]); end
      btn_up = 0; tick();
      vectors++; if (scroll_rst !== exp_s[k]) begin
        errors++; $display("FAIL up_run_%0d: got %b want %b", k, scroll_rst, exp_s[k]); end
    end
  endtask

  task automatic test_both_timeout();
    btn_up = 1; tick(); btn_up = 0; tick(); btn_up = 1; tick(); btn_up = 0; tick();
    btn_up = 1; btn_down = 1; tick();
    vectors++; if (page !== 2'd2 || scroll_rst !== 4'b1011) begin
      errors++; $display("FAIL both_press: got page=%0d scroll=%b want 2 1011", page, scroll_rst); end
    btn_up = 0; btn_down = 0;
    for (int i = 1; i < TO; i++) begin
      tick();
      vectors++; if (page !== 2'd2 || timeout !== 1'b0) begin
        errors++; $display("FAIL early_to_%0d: got page=%0d to=%b want 2 0", i, page, timeout); end
    end
    tick();
    vectors++; if (page !== 2'd0 || timeout !== 1'b1 || scroll_rst !== 4'b1111) begin
      errors++; $display("FAIL timeout: got page=%0d to=%b scroll=%b want 0 1 1111", page, timeout, scroll_rst); end
    tick();
    vectors++; if (timeout !== 1'b0 || scroll_rst !== 4'b1110) begin
      errors++; $display("FAIL timeout_pulse: got to=%b scroll=%b want 0 1110", timeout, scroll_rst); end
  endtask

  task automatic test_select();
    btn_down = 1; tick(); btn_down = 0; tick();
    btn_sel = 1; tick();
    vectors++; if (sel_valid !== 1'b1 || sel_op !== 2'd1) begin
      errors++; $display("FAIL sel: got valid=%b op=%0d want 1 1", sel_valid, sel_op); end
    btn_sel = 0;
    for (int i = 0; i < 5; i++) begin
      btn_up = (i % 2 == 0); tick();
      vectors++; if (sel_valid !== 1'b1 || sel_op !== 2'd1 || page !== 2'd1) begin
        errors++; $display("FAIL confirm_hold_%0d: got valid=%b op=%0d page=%0d want 1 1 1", i, sel_valid, sel_op, page); end
    end
    btn_up = 0; sel_ack = 1; tick();
    vectors++; if (sel_valid !== 1'b0 || page !== 2'd1) begin
      errors++; $display("FAIL ack: got valid=%b page=%0d want 0 1", sel_valid, page); end
    sel_ack = 0; tick();
    vectors++; if (scroll_rst !== 4'b1101) begin errors++; $display("FAIL ack_norestart: got %b want 1101", scroll_rst); end
    btn_up = 1; tick();
    vectors++; if (page !== 2'd0) begin errors++; $display("FAIL after_ack_up: got %0d want 0", page); end
    btn_up = 0; tick();
  endtask

  task automatic test_abort();
    btn_down = 1; tick(); btn_down = 0; tick(); btn_down = 1; tick(); btn_down = 0; tick();
    btn_sel = 1; tick();
    vectors++; if (sel_valid !== 1'b1 || sel_op !== 2'd2) begin
      errors++; $display("FAIL abort_sel: got valid=%b op=%0d want 1 2", sel_valid, sel_op); end
    btn_sel = 0; state = 4'd3; tick();
    vectors++; if (sel_valid !== 1'b0 || page !== 2'd0 || scroll_rst !== 4'b1111 || timeout !== 1'b0) begin
      errors++; $display("FAIL abort: got valid=%b page=%0d scroll=%b to=%b want 0 0 1111 0", sel_valid, page, scroll_rst, timeout); end
    tick();
    state = 4'd0; tick();
    vectors++; if (page !== 2'd0 || scroll_rst !== 4'b1111) begin
      errors++; $display("FAIL reenter: got page=%0d scroll=%b want 0 1111", page, scroll_rst); end
    tick();
    vectors++; if (scroll_rst !== 4'b1110) begin errors++; $display("FAIL reenter_run: got %b want 1110", scroll_rst); end
    btn_down = 1; tick();
    vectors++; if (page !== 2'd1) begin errors++; $display("FAIL reenter_down: got %0d want 1", page); end
    btn_down = 0; tick();
  endtask

  task automatic test_reset_mid_confirm();
    btn_down = 1; tick(); btn_down = 0; tick();
    btn_sel = 1; tick();
    vectors++; if (sel_valid !== 1'b1 || sel_op !== 2'd2) begin
      errors++; $display("FAIL mid_sel: got valid=%b op=%0d want 1 2", sel_valid, sel_op); end
    btn_sel = 0; rst = 0; tick();
    vectors++; if (page !== 2'd0 || scroll_rst !== 4'b1111 || sel_valid !== 1'b0 || sel_op !== 2'd0 || timeout !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got page=%0d scroll=%b valid=%b op=%0d to=%b want 0 1111 0 0 0",
                         page, scroll_rst, sel_valid, sel_op, timeout); end
    rst = 1; tick();
  endtask

  task automatic test_random();
    bit busy = 1;
    rst = 0; btn_up = 0; btn_down = 0; btn_sel = 0; sel_ack = 0; state = 4'd0;
    tick();
    rst = 1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 40 == 0) busy = ($urandom_range(0, 2) != 0);
      rst   = ($urandom_range(0, 299) != 0);
      state = ($urandom_range(0, 79) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      if (busy) begin
        if ($urandom_range(0, 2) == 0) btn_up   = ~btn_up;
        if ($urandom_range(0, 2) == 0) btn_down = ~btn_down;
        if ($urandom_range(0, 5) == 0) btn_sel  = ~btn_sel;
      end
      sel_ack = ($urandom_range(0, 3) == 0);
      tick();
      vectors++; if (page !== 2'(m_page)) begin errors++; $display("FAIL rnd_page c=%0d: got %0d want %0d", c, page, m_page); end
      vectors++; if (scroll_rst !== m_scroll()) begin errors++; $display("FAIL rnd_scroll c=%0d: got %b want %b", c, scroll_rst, m_scroll()); end
      vectors++; if (sel_valid !== m_selv) begin errors++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, sel_valid, m_selv); end
      vectors++; if (sel_op !== 2'(m_op)) begin errors++; $display("FAIL rnd_op c=%0d: got %0d want %0d", c, sel_op, m_op); end
      vectors++; if (timeout !== m_to) begin errors++; $display("FAIL rnd_timeout c=%0d: got %b want %b", c, timeout, m_to); end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_both_timeout();
    test_select();
    test_abort();
    test_reset_mid_confirm();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
